trees_acc_host_ctrl: RTL and testbench

TREES_ACC_HOST_CTRL -- requirements
Module: trees_acc_host_ctrl

---
 rtl/trees_acc_host_ctrl.sv | 177 +++++++++++++++++
 tb/tb_trees_acc_host_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trees_acc_host_ctrl.sv
// Host-side controller for the trees accelerator: streams tree nodes and feature
// words into the accelerator, launches a burst and returns packed 8-bit predictions.
module trees_acc_host_ctrl #(
  parameter int unsigned N_TREES          = 128,
  parameter int unsigned N_NODE_AND_LEAFS = 256,
  parameter int unsigned MAX_BURST        = 54,
  parameter int unsigned TREES_LEN_BITS   = $clog2(N_NODE_AND_LEAFS),
  parameter int unsigned TREE_IDX_BITS    = $clog2(N_TREES),
  parameter int unsigned MAX_BURST_BITS   = $clog2(MAX_BURST)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_op,
  input  logic [MAX_BURST_BITS-1:0] cmd_burst_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [63:0]               in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [63:0]               out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      acc_load_trees,
  output logic [TREES_LEN_BITS-1:0] acc_n_node,
  output logic [TREE_IDX_BITS-1:0]  acc_n_tree,
  output logic [63:0]               acc_tree_nodes,
  output logic                      acc_load_features,
  output logic [31:0]               acc_feature_addr,
  output logic [63:0]               acc_features2,
  output logic [MAX_BURST_BITS-1:0] acc_burst_len,
  output logic                      acc_start,
  input  logic                      acc_done,
  output logic [MAX_BURST_BITS-1:0] acc_prediction_addr,
  input  logic [63:0]               acc_prediction
);

  // 16 feature words per sample
  localparam int unsigned FEAT_BITS = MAX_BURST_BITS + 4;

  typedef enum logic [2:0] {
    IDLE, LOAD_TREES, LOAD_FEAT, START, WAIT_DONE, RD_ADDR, RD_CAP, OUT_HOLD
  } state_t;

  state_t                    state;
  logic [MAX_BURST_BITS-1:0] len;
  logic [MAX_BURST_BITS-1:0] clamp_len;
  logic [MAX_BURST_BITS-1:0] last_k;
  logic [FEAT_BITS-1:0]      feat_cnt;
  logic [FEAT_BITS-1:0]      feat_last;
  logic                      node_last;
  logic                      tree_last;
  logic                      in_fire;

  assign clamp_len = (cmd_burst_len > MAX_BURST_BITS'(MAX_BURST)) ?
                     MAX_BURST_BITS'(MAX_BURST) : cmd_burst_len;
  assign feat_last = {len, 4'b0000} - FEAT_BITS'(1);
  assign last_k    = (len - MAX_BURST_BITS'(1)) >> 3;
  assign node_last = (acc_n_node == TREES_LEN_BITS'(N_NODE_AND_LEAFS - 1));
  assign tree_last = (acc_n_tree == TREE_IDX_BITS'(N_TREES - 1));
  assign in_fire   = in_valid & in_ready;

  // Write strobes fire only in the handshake cycle so a stalled source writes nothing
  assign acc_load_trees    = in_fire & (state == LOAD_TREES);
  assign acc_load_features = in_fire & (state == LOAD_FEAT);
  assign acc_tree_nodes    = acc_load_trees ? in_data : 64'd0;
  assign acc_features2     = acc_load_features ? in_data : 64'd0;
  assign acc_feature_addr  = 32'(feat_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      len                 <= '0;
      feat_cnt            <= '0;
      cmd_ready           <= 1'b1;
      in_ready            <= 1'b0;
      busy                <= 1'b0;
      out_valid           <= 1'b0;
      out_data            <= 64'd0;
      out_last            <= 1'b0;
      acc_n_node          <= '0;
      acc_n_tree          <= '0;
      acc_burst_len       <= '0;
      acc_start           <= 1'b0;
      acc_prediction_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            if (!cmd_op) begin
              state      <= LOAD_TREES;
              cmd_ready  <= 1'b0;
              in_ready   <= 1'b1;
              busy       <= 1'b1;
              acc_n_node <= '0;
              acc_n_tree <= '0;
            end else if (clamp_len != '0) begin
              state     <= LOAD_FEAT;
              len       <= clamp_len;
              feat_cnt  <= '0;
              cmd_ready <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        LOAD_TREES: begin
          if (in_valid) begin
            if (node_last && tree_last) begin
              state      <= IDLE;
              in_ready   <= 1'b0;
              busy       <= 1'b0;
              cmd_ready  <= 1'b1;
              acc_n_node <= '0;
              acc_n_tree <= '0;
            end else if (node_last) begin
              acc_n_node <= '0;
              acc_n_tree <= acc_n_tree + TREE_IDX_BITS'(1);
            end else begin
              acc_n_node <= acc_n_node + TREES_LEN_BITS'(1);
            end
          end
        end
        LOAD_FEAT: begin
          if (in_valid) begin
            if (feat_cnt == feat_last) begin
              // acc_start is visible during START so acc_done is only sampled afterwards
              state         <= START;
              in_ready      <= 1'b0;
              feat_cnt      <= '0;
              acc_start     <= 1'b1;
              acc_burst_len <= len;
            end else begin
              feat_cnt <= feat_cnt + FEAT_BITS'(1);
            end
          end
        end
        START: begin
          acc_start <= 1'b0;
          state     <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (acc_done) begin
            acc_prediction_addr <= '0;
            state               <= RD_ADDR;
          end
        end
        RD_ADDR: state <= RD_CAP;
        RD_CAP: begin
          out_data  <= acc_prediction;
          out_valid <= 1'b1;
          out_last  <= (acc_prediction_addr == last_k);
          state     <= OUT_HOLD;
        end
        OUT_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state               <= IDLE;
              busy                <= 1'b0;
              cmd_ready           <= 1'b1;
              acc_burst_len       <= '0;
              acc_prediction_addr <= '0;
            end else begin
              acc_prediction_addr <= acc_prediction_addr + MAX_BURST_BITS'(1);
              state               <= RD_ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trees_acc_host_ctrl.sv
// Directed bench for trees_acc_host_ctrl: tree load, feature bursts, output
// back-pressure, length clamping and reset during a feature load.
module tb_trees_acc_host_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [5:0]  cmd_burst_len;
  logic        in_valid, in_ready;
  logic [63:0] in_data;
  logic        out_valid, out_ready, out_last, busy;
  logic [63:0] out_data;
  logic        acc_load_trees;
  logic [7:0]  acc_n_node;
  logic [6:0]  acc_n_tree;
  logic [63:0] acc_tree_nodes;
  logic        acc_load_features;
  logic [31:0] acc_feature_addr;
  logic [63:0] acc_features2;
  logic [5:0]  acc_burst_len;
  logic        acc_start, acc_done;
  logic [5:0]  acc_prediction_addr;
  logic [63:0] acc_prediction;

  int cmp_count = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  trees_acc_host_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_burst_len(cmd_burst_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy),
    .acc_load_trees(acc_load_trees), .acc_n_node(acc_n_node),
    .acc_n_tree(acc_n_tree), .acc_tree_nodes(acc_tree_nodes),
    .acc_load_features(acc_load_features), .acc_feature_addr(acc_feature_addr),
    .acc_features2(acc_features2), .acc_burst_len(acc_burst_len),
    .acc_start(acc_start), .acc_done(acc_done),
    .acc_prediction_addr(acc_prediction_addr), .acc_prediction(acc_prediction)
  );

  function automatic logic [63:0] pat(input logic [5:0] a);
    return 64'h0123_4567_89AB_CDEF ^ {8{{2'b00, a}}};
  endfunction

  // Accelerator prediction memory: one-cycle read latency
  always @(posedge clk) acc_prediction <= pat(acc_prediction_addr);

  task automatic send_cmd(input logic op, input logic [5:0] blen);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_burst_len = blen;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    cmp_count++;
    if ({cmd_ready, in_ready, busy, out_valid, out_last, acc_start, acc_load_trees,
         acc_load_features} !== 8'b1000_0000) begin
      fail_count++;
      $display("FAIL reset_flags got %b want 10000000", {cmd_ready, in_ready, busy,
               out_valid, out_last, acc_start, acc_load_trees, acc_load_features});
    end
    cmp_count++;
    if ({out_data, acc_feature_addr, acc_n_node, acc_n_tree, acc_burst_len,
         acc_prediction_addr} !== 123'd0) begin
      fail_count++;
      $display("FAIL reset_values got nonzero out_data=%h addr=%0d node=%0d tree=%0d",
               out_data, acc_feature_addr, acc_n_node, acc_n_tree);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_tree_load();
    int n = 0;
    int idx_err = 0;
    int data_err = 0;
    send_cmd(1'b0, 6'd0);
    in_valid = 1'b1;
    in_data = {32'hC0DE_0000, 32'd0};
    for (int cyc = 0; cyc < 40000 && n < 32768; cyc++) begin
      @(negedge clk);
      if (acc_load_trees) begin
        if (acc_n_node !== 8'(n % 256) || acc_n_tree !== 7'(n / 256)) idx_err++;
        if (acc_tree_nodes !== in_data) data_err++;
        if (n == 0) begin
          cmp_count++;
          if (acc_n_node !== 8'd0 || acc_n_tree !== 7'd0) begin
            fail_count++;
            $display("FAIL tree_first got node %0d tree %0d want 0/0", acc_n_node, acc_n_tree);
          end
        end
        if (n == 256) begin
          cmp_count++;
          if (acc_n_node !== 8'd0 || acc_n_tree !== 7'd1) begin
            fail_count++;
            $display("FAIL tree_word256 got node %0d tree %0d want 0/1", acc_n_node, acc_n_tree);
          end
        end
        if (n == 32767) begin
          cmp_count++;
          if (acc_n_node !== 8'd255 || acc_n_tree !== 7'd127) begin
            fail_count++;
            $display("FAIL tree_last got node %0d tree %0d want 255/127", acc_n_node, acc_n_tree);
          end
        end
        n++;
      end
      @(posedge clk); #1;
      in_data = {32'hC0DE_0000, 32'(n)};
    end
    in_valid = 1'b0;
    @(negedge clk);
    cmp_count++;
    if (n !== 32768) begin
      fail_count++;
      $display("FAIL tree_count got %0d want 32768", n);
    end
    cmp_count++;
    if (idx_err !== 0 || data_err !== 0) begin
      fail_count++;
      $display("FAIL tree_write got idx_err %0d data_err %0d want 0/0", idx_err, data_err);
    end
    cmp_count++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fail_count++;
      $display("FAIL tree_done got cmd_ready %b busy %b want 1/0", cmd_ready, busy);
    end
  endtask

  // Drives one run burst and checks feature writes, start pulse and output words
  task automatic run_burst(input logic [5:0] blen, input int exp_len, input int done_delay,
                           input bit toggle, input int stall);
    int nfeat = 0;
    int addr_err = 0;
    int data_err = 0;
    int gate_err = 0;
    int starts = 0;
    int t = 0;
    bit started = 0;
    int words = 0;
    int hold = 0;
    int stab_err = 0;
    int exp_words = (exp_len + 7) / 8;
    send_cmd(1'b1, blen);
    in_valid = 1'b1;
    in_data = {32'hF00D_0000, 32'd0};
    for (int cyc = 0; cyc < 4000 && nfeat < exp_len * 16; cyc++) begin
      @(negedge clk);
      if (!in_valid && acc_load_features) gate_err++;
      if (acc_load_features) begin
        if (acc_feature_addr !== 32'(nfeat)) addr_err++;
        if (acc_features2 !== in_data) data_err++;
        nfeat++;
      end
      @(posedge clk); #1;
      in_valid = toggle ? ~in_valid : 1'b1;
      in_data = {32'hF00D_0000, 32'(nfeat)};
    end
    in_valid = 1'b0;
    cmp_count++;
    if (nfeat !== exp_len * 16) begin
      fail_count++;
      $display("FAIL feat_count len %0d got %0d want %0d", exp_len, nfeat, exp_len * 16);
    end
    cmp_count++;
    if (addr_err !== 0 || data_err !== 0 || gate_err !== 0) begin
      fail_count++;
      $display("FAIL feat_write got addr_err %0d data_err %0d gate_err %0d want 0/0/0",
               addr_err, data_err, gate_err);
    end
    for (int cyc = 0; cyc < 3000 && words < exp_words; cyc++) begin
      @(negedge clk);
      if (acc_start) begin
        starts++;
        started = 1;
        cmp_count++;
        if (acc_burst_len !== 6'(exp_len)) begin
          fail_count++;
          $display("FAIL burst_len got %0d want %0d", acc_burst_len, exp_len);
        end
      end
      if (out_valid && !out_ready && out_data !== pat(6'(words))) stab_err++;
      if (out_valid && out_ready) begin
        cmp_count++;
        if (out_data !== pat(6'(words)) || out_last !== (words == exp_words - 1)) begin
          fail_count++;
          $display("FAIL out_word %0d got %h last %b want %h last %b", words, out_data,
                   out_last, pat(6'(words)), words == exp_words - 1);
        end
        words++;
      end
      @(posedge clk); #1;
      if (started) begin
        t++;
        if (t == done_delay) acc_done = 1'b1;
      end
      if (out_valid) begin
        out_ready = (hold >= stall);
        hold++;
      end else begin
        out_ready = 1'b0;
        hold = 0;
      end
    end
    acc_done = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    cmp_count++;
    if (words !== exp_words || starts !== 1) begin
      fail_count++;
      $display("FAIL run_totals got words %0d starts %0d want %0d/1", words, starts, exp_words);
    end
    cmp_count++;
    if (stab_err !== 0) begin
      fail_count++;
      $display("FAIL out_stable got %0d changes want 0", stab_err);
    end
    cmp_count++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      fail_count++;
      $display("FAIL run_idle got cmd_ready %b busy %b out_valid %b want 1/0/0",
               cmd_ready, busy, out_valid);
    end
  endtask

  task automatic test_run_full();
    run_burst(6'd54, 54, 100, 1'b0, 0);
  endtask

  task automatic test_run_stall();
    run_burst(6'd8, 8, 3, 1'b1, 5);
  endtask

  task automatic test_clamp();
    run_burst(6'd63, 54, 4, 1'b0, 1);
  endtask

  task automatic test_zero_len();
    int bad = 0;
    send_cmd(1'b1, 6'd0);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || acc_start !== 1'b0 ||
          in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    cmp_count++;
    if (bad !== 0) begin
      fail_count++;
      $display("FAIL zero_len got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid_feat();
    int n = 0;
    send_cmd(1'b1, 6'd54);
    in_valid = 1'b1;
    in_data = 64'd0;
    for (int cyc = 0; cyc < 1000 && n < 300; cyc++) begin
      @(negedge clk);
      if (acc_load_features) n++;
      @(posedge clk); #1;
      in_data = 64'(n);
    end
    cmp_count++;
    if (acc_feature_addr !== 32'd300 || busy !== 1'b1) begin
      fail_count++;
      $display("FAIL pre_reset_addr got %0d busy %b want 300/1", acc_feature_addr, busy);
    end
    rst = 1'b1;
    #1;
    cmp_count++;
    if ({cmd_ready, in_ready, busy, acc_load_features, acc_start, out_valid} !== 6'b100000 ||
        acc_feature_addr !== 32'd0 || acc_burst_len !== 6'd0) begin
      fail_count++;
      $display("FAIL mid_reset got flags %b addr %0d blen %0d want 100000/0/0",
               {cmd_ready, in_ready, busy, acc_load_features, acc_start, out_valid},
               acc_feature_addr, acc_burst_len);
    end
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    run_burst(6'd1, 1, 2, 1'b0, 0);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_burst_len = 6'd0;
    in_valid = 1'b0; in_data = 64'd0;
    out_ready = 1'b0; acc_done = 1'b0;
    test_reset();
    test_tree_load();
    test_run_full();
    test_run_stall();
    test_clamp();
    test_zero_len();
    test_reset_mid_feat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
